// File: rtl/commit_unit.sv
// commit_unit
// Retirement stage sitting behind the completion buffer head. Each cycle in
// RUN it retires at most one instruction: scalar write-back, vector-commit
// wait, flush on exception/mispredict, or halt. It is the only writer of
// the architectural scalar register file and maintains the retired-
// instruction counter.
//
// Ports:
//   CLK, nRST               clock, asynchronous active-low reset
//   scalar_commit_ena       head is a completed scalar instruction
//   vd_final, wdata_final   head destination register / result
//   exception, mal_priv     head raised an exception / it is mal-or-priv
//   branch_mispredict_ena   head is a mispredicted branch
//   halt_instr              head is a halt instruction
//   rv32v_commit_ena/_done  vector head ready / vector unit finished
//   commit_ready            combinational, high only in RUN
//   rf_wen/_waddr/_wdata    registered register-file write port
//   flush_req               registered flush request to the hazard unit
//   exc_valid, exc_mal      one-cycle exception pulse and its qualifier
//   halt                    sticky halted flag
//   instret                 retired-instruction counter (wraps)
module commit_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int INSTRET_W    = 64
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 scalar_commit_ena,
    input  logic [4:0]           vd_final,
    input  logic [31:0]          wdata_final,
    input  logic                 exception,
    input  logic                 mal_priv,
    input  logic                 branch_mispredict_ena,
    input  logic                 halt_instr,
    input  logic                 rv32v_commit_ena,
    input  logic                 rv32v_commit_done,
    output logic                 commit_ready,
    output logic                 rf_wen,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 flush_req,
    output logic                 exc_valid,
    output logic                 exc_mal,
    output logic                 halt,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_VWAIT  = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam int               CNT_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rf_wen_q, rf_wen_d;
    logic [4:0]           rf_waddr_q, rf_waddr_d;
    logic [31:0]          rf_wdata_q, rf_wdata_d;
    logic                 flush_q, flush_d;
    logic                 exc_valid_q, exc_valid_d;
    logic                 exc_mal_q, exc_mal_d;
    logic                 halt_q, halt_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 retire;
    logic                 do_write;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_d      = halt_q;
        exc_valid_d = 1'b0;
        exc_mal_d   = 1'b0;
        retire      = 1'b0;
        do_write    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (halt_instr) begin
                    retire  = 1'b1;
                    halt_d  = 1'b1;
                    state_d = ST_HALTED;
                end else if (exception) begin
                    // Faulting instruction does not retire and never writes.
                    exc_valid_d = 1'b1;
                    exc_mal_d   = mal_priv;
                    cnt_d       = FLUSH_LOAD;
                    state_d     = ST_FLUSH;
                end else if (branch_mispredict_ena) begin
                    // The branch itself is correct; only younger work is flushed.
                    retire   = 1'b1;
                    do_write = scalar_commit_ena && (vd_final != 5'd0);
                    cnt_d    = FLUSH_LOAD;
                    state_d  = ST_FLUSH;
                end else if (rv32v_commit_ena) begin
                    if (rv32v_commit_done) begin
                        retire = 1'b1;
                    end else begin
                        state_d = ST_VWAIT;
                    end
                end else if (scalar_commit_ena) begin
                    retire   = 1'b1;
                    do_write = (vd_final != 5'd0);
                end
            end
            ST_VWAIT: begin
                if (rv32v_commit_done) begin
                    retire  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // HALTED absorbs everything until reset.
            end
        endcase

        rf_wen_d   = do_write;
        rf_waddr_d = do_write ? vd_final    : rf_waddr_q;
        rf_wdata_d = do_write ? wdata_final : rf_wdata_q;
        instret_d  = instret_q + {{(INSTRET_W-1){1'b0}}, retire};
        // Registered flush_req mirrors residency in FLUSH without a decode delay.
        flush_d    = (state_d == ST_FLUSH);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= 5'd0;
            rf_wdata_q  <= 32'd0;
            flush_q     <= 1'b0;
            exc_valid_q <= 1'b0;
            exc_mal_q   <= 1'b0;
            halt_q      <= 1'b0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            flush_q     <= flush_d;
            exc_valid_q <= exc_valid_d;
            exc_mal_q   <= exc_mal_d;
            halt_q      <= halt_d;
            instret_q   <= instret_d;
        end
    end

    assign commit_ready = (state_q == ST_RUN);
    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign flush_req    = flush_q;
    assign exc_valid    = exc_valid_q;
    assign exc_mal      = exc_mal_q;
    assign halt         = halt_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit
// Directed test-plan scenarios plus randomized retirement traffic, checked
// cycle by cycle against a behavioural model built from the retirement
// rules (remaining-flush count, pending-vector flag, halted flag, counter).
module tb_commit_unit;

    localparam int FC = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        scalar_commit_ena = 1'b0;
    logic [4:0]  vd_final = '0;
    logic [31:0] wdata_final = '0;
    logic        exception = 1'b0;
    logic        mal_priv = 1'b0;
    logic        branch_mispredict_ena = 1'b0;
    logic        halt_instr = 1'b0;
    logic        rv32v_commit_ena = 1'b0;
    logic        rv32v_commit_done = 1'b0;
    logic        commit_ready, rf_wen, flush_req, exc_valid, exc_mal, halt;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] instret;

    commit_unit #(.FLUSH_CYCLES(FC), .INSTRET_W(64)) dut (
        .CLK(CLK), .nRST(nRST),
        .scalar_commit_ena(scalar_commit_ena), .vd_final(vd_final),
        .wdata_final(wdata_final), .exception(exception), .mal_priv(mal_priv),
        .branch_mispredict_ena(branch_mispredict_ena), .halt_instr(halt_instr),
        .rv32v_commit_ena(rv32v_commit_ena), .rv32v_commit_done(rv32v_commit_done),
        .commit_ready(commit_ready), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .flush_req(flush_req), .exc_valid(exc_valid),
        .exc_mal(exc_mal), .halt(halt), .instret(instret)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, cycle_no, got, exp);
        end
    endtask

    // Behavioural model
    int          m_flush_left;
    bit          m_vwait, m_halted;
    bit [63:0]   m_instret;
    bit          m_wen, m_exc, m_mal;
    bit [4:0]    m_waddr;
    bit [31:0]   m_wdata;

    function automatic void model_reset();
        m_flush_left = 0; m_vwait = 0; m_halted = 0; m_instret = 0;
        m_wen = 0; m_exc = 0; m_mal = 0; m_waddr = 0; m_wdata = 0;
    endfunction

    function automatic void model_write(bit [4:0] a, bit [31:0] d);
        if (a != 0) begin
            m_wen = 1; m_waddr = a; m_wdata = d;
        end
    endfunction

    function automatic void model_step();
        m_wen = 0; m_exc = 0; m_mal = 0;
        if (m_halted) begin
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (m_vwait) begin
            if (rv32v_commit_done) begin
                m_instret++; m_vwait = 0;
            end
        end else if (halt_instr) begin
            m_instret++; m_halted = 1;
        end else if (exception) begin
            m_exc = 1; m_mal = mal_priv; m_flush_left = FC;
        end else if (branch_mispredict_ena) begin
            m_instret++;
            if (scalar_commit_ena) model_write(vd_final, wdata_final);
            m_flush_left = FC;
        end else if (rv32v_commit_ena) begin
            if (rv32v_commit_done) m_instret++;
            else m_vwait = 1;
        end else if (scalar_commit_ena) begin
            m_instret++;
            model_write(vd_final, wdata_final);
        end
    endfunction

    task automatic compare_all();
        check("commit_ready", commit_ready, (!m_halted && !m_vwait && m_flush_left == 0));
        check("rf_wen", rf_wen, m_wen);
        check("rf_waddr", rf_waddr, m_waddr);
        check("rf_wdata", rf_wdata, m_wdata);
        check("flush_req", flush_req, (m_flush_left > 0));
        check("exc_valid", exc_valid, m_exc);
        check("exc_mal", exc_mal, m_mal);
        check("halt", halt, m_halted);
        check("instret", instret, m_instret);
        if (rf_wen)
            $display("cycle=%0d WB x%0d=0x%08h instret=%0d", cycle_no, rf_waddr, rf_wdata, instret);
    endtask

    // One clock: compare what the last edge produced, then present new inputs.
    task automatic cyc(input bit s, input bit [4:0] vd, input bit [31:0] wd,
                       input bit exc, input bit mal, input bit mp, input bit h,
                       input bit ve, input bit vdn);
        @(negedge CLK);
        cycle_no++;
        compare_all();
        scalar_commit_ena = s; vd_final = vd; wdata_final = wd;
        exception = exc; mal_priv = mal; branch_mispredict_ena = mp;
        halt_instr = h; rv32v_commit_ena = ve; rv32v_commit_done = vdn;
        model_step();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic zero_inputs();
        scalar_commit_ena = 0; vd_final = 0; wdata_final = 0; exception = 0;
        mal_priv = 0; branch_mispredict_ena = 0; halt_instr = 0;
        rv32v_commit_ena = 0; rv32v_commit_done = 0;
    endtask

    int        low_cnt;
    bit [63:0] base;

    initial begin
        model_reset();
        zero_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        // Reset state and back-to-back scalar commits
        idle();
        cyc(1, 5, 32'hA, 0, 0, 0, 0, 0, 0);
        cyc(1, 6, 32'hB, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'hC, 0, 0, 0, 0, 0, 0);
        idle(); idle();
        check("tp_scalar_instret", instret, 64'd3);

        // Vector wait: done sampled 4 cycles after the stall starts
        base = m_instret;
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        low_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 1, (i == 3));
            if (!commit_ready) low_cnt++;
            if (i < 3) check("tp_vwait_instret_hold", instret, base);
        end
        idle();
        if (!commit_ready) low_cnt++;
        check("tp_vwait_ready_low", low_cnt, 4);
        check("tp_vwait_instret", instret, base + 1);

        // Exception with scalar ena, mal_priv=1
        base = m_instret;
        cyc(1, 7, 32'h77, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) idle();
        check("tp_exc_instret", instret, base);

        // Mispredict writing x1, scalar commits during flush are ignored
        cyc(1, 1, 32'h44, 0, 0, 1, 0, 0, 0);
        cyc(1, 9, 32'h99, 0, 0, 0, 0, 0, 0);
        cyc(1, 10, 32'h98, 0, 0, 0, 0, 0, 0);
        idle(); idle();
        check("tp_mp_instret", instret, base + 1);

        // Randomized traffic, halt excluded
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 2) == 0,
                (($urandom % 6) == 0) ? 5'd0 : 5'($urandom),
                $urandom,
                ($urandom % 14) == 0, $urandom % 2,
                ($urandom % 12) == 0, 1'b0,
                ($urandom % 6) == 0, ($urandom % 3) == 0);
        end

        // Asynchronous reset in the middle of a flush
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle();
        check("tp_rst_pre_flush", flush_req, 1'b1);
        #2 nRST = 1'b0;
        #1;
        check("tp_rst_ready", commit_ready, 1'b1);
        check("tp_rst_flush", flush_req, 1'b0);
        check("tp_rst_rf_wen", rf_wen, 1'b0);
        check("tp_rst_exc", exc_valid, 1'b0);
        check("tp_rst_instret", instret, 64'd0);
        check("tp_rst_halt", halt, 1'b0);
        zero_inputs();
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        idle();
        idle();

        // Halt wins over exception and scalar commit, then stays halted
        base = m_instret;
        cyc(1, 3, 32'h33, 1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 5'(i + 1), 32'(i), 0, 0, 0, 0, 0, 0);
        idle();
        check("tp_halt_flag", halt, 1'b1);
        check("tp_halt_instret", instret, base + 1);
        check("tp_halt_ready", commit_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
